// File: rtl/shift_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg_pkg
// Description : Mode codes, burst states and burst directions shared by the
//               universal shift register and its burst controller.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_reg_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_ROR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_LOAD = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } burst_state_e;

    localparam logic DIR_R = 1'b0;
    localparam logic DIR_L = 1'b1;

endpackage
`default_nettype wire

// File: rtl/shift_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : shift_burst_ctrl
// Description : Burst sequencer: accepts start, clamps the length, counts
//               shifts down and produces busy/done plus datapath strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_burst_ctrl
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             dir,
    output logic             busy,
    output logic             done,
    output logic             shift_stb,
    output logic             dir_lat,
    output logic             load_stb
);

    localparam logic [CNT_W-1:0] C_LEN_MAX = CNT_W'(WIDTH);

    burst_state_e     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dir_q;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] w_len_clamp;

    assign w_len_clamp = (len > C_LEN_MAX) ? C_LEN_MAX : len;
    // Start may retrigger from FIN so back-to-back bursts leave no idle gap.
    assign load_stb    = en & start & (state_q != ST_RUN);
    assign shift_stb   = en & (state_q == ST_RUN);
    assign busy        = busy_q;
    assign done        = done_q;
    assign dir_lat     = dir_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dir_q   <= DIR_R;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (en) begin
            if (start && (state_q != ST_RUN)) begin
                cnt_q <= w_len_clamp;
                dir_q <= dir;
                if (w_len_clamp != '0) begin
                    state_q <= ST_RUN;
                    busy_q  <= 1'b1;
                    done_q  <= 1'b0;
                end else begin
                    state_q <= ST_FIN;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
            end else begin
                case (state_q)
                    ST_RUN: begin
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= ST_FIN;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                    ST_FIN: begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : univ_shift_reg
// Description : Parametrised universal shift register with eight modes and a
//               load-then-shift burst serialiser.
// Revision    : 1.0 - initial release
// ============================================================================
module univ_shift_reg
    import shift_reg_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             s_in_msb,
    input  logic             s_in_lsb,
    input  logic [WIDTH-1:0] p_in,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             dir,
    output logic [WIDTH-1:0] q,
    output logic             s_out_lsb,
    output logic             s_out_msb,
    output logic             busy,
    output logic             done
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             w_busy;
    logic             w_shift;
    logic             w_load;
    logic             w_dir;

    shift_burst_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .start     (start),
        .len       (len),
        .dir       (dir),
        .busy      (w_busy),
        .done      (done),
        .shift_stb (w_shift),
        .dir_lat   (w_dir),
        .load_stb  (w_load)
    );

    // Priority: burst load, then burst shift, then the free-running mode.
    always_comb begin
        q_d = q_q;
        if (w_load) begin
            q_d = p_in;
        end else if (w_shift) begin
            q_d = (w_dir == DIR_L) ? {q_q[WIDTH-2:0], s_in_lsb}
                                   : {s_in_msb, q_q[WIDTH-1:1]};
        end else if (en && !w_busy) begin
            case (mode)
                MODE_HOLD: q_d = q_q;
                MODE_SHR:  q_d = {s_in_msb, q_q[WIDTH-1:1]};
                MODE_SHL:  q_d = {q_q[WIDTH-2:0], s_in_lsb};
                MODE_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
                MODE_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                MODE_LOAD: q_d = p_in;
                MODE_ASR:  q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                MODE_CLR:  q_d = '0;
                default:   q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q         = q_q;
    assign s_out_lsb = q_q[0];
    assign s_out_msb = q_q[WIDTH-1];
    assign busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_univ_shift_reg
// Description : Self-checking bench: directed scenarios plus a randomized run
//               against a behavioural burst/mode model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic [2:0] mode = 3'b000;
    logic       s_in_msb = 1'b0;
    logic       s_in_lsb = 1'b0;
    logic [7:0] p_in = 8'h00;
    logic       start = 1'b0;
    logic [3:0] len = 4'd0;
    logic       dir = 1'b0;
    logic [7:0] q;
    logic       s_out_lsb;
    logic       s_out_msb;
    logic       busy;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    int m_q    = 0;
    int m_left = 0;
    bit m_fin  = 1'b0;
    bit m_dir  = 1'b0;

    univ_shift_reg #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .s_in_msb  (s_in_msb),
        .s_in_lsb  (s_in_lsb),
        .p_in      (p_in),
        .start     (start),
        .len       (len),
        .dir       (dir),
        .q         (q),
        .s_out_lsb (s_out_lsb),
        .s_out_msb (s_out_msb),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        #2 rst_n = 1'b0;
        start = 1'b0; en = 1'b1; mode = 3'b000;
        tick();
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic do_load(input logic [7:0] v);
        mode = 3'b101; p_in = v;
        tick();
    endtask

    // One enabled edge of the model: shift/load rules computed arithmetically.
    task automatic model_step(input bit e, input bit st, input int md, input int p,
                              input int ln, input bit d, input bit sm, input bit sl);
        int n;
        if (!e) return;
        if (st && m_left == 0) begin
            n = (ln > 8) ? 8 : ln;
            m_q = p; m_dir = d; m_left = n; m_fin = (n == 0);
        end else if (m_left > 0) begin
            m_q = m_dir ? (((m_q * 2) % 256) + sl) : ((m_q / 2) + (sm ? 128 : 0));
            m_left = m_left - 1;
            m_fin = (m_left == 0);
        end else begin
            m_fin = 1'b0;
            case (md)
                1: m_q = (m_q / 2) + (sm ? 128 : 0);
                2: m_q = ((m_q * 2) % 256) + sl;
                3: m_q = (m_q / 2) + ((m_q % 2) * 128);
                4: m_q = ((m_q * 2) % 256) + (m_q / 128);
                5: m_q = p;
                6: m_q = (m_q / 2) + (m_q >= 128 ? 128 : 0);
                7: m_q = 0;
                default: m_q = m_q;
            endcase
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_tests++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_initial: q=%h busy=%b done=%b, want q=00 busy=0 done=0", q, busy, done);
        end
        rst_n = 1'b1;
        tick();
        p_in = 8'hFF; len = 4'd8; dir = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: q=%h busy=%b done=%b, want q=00 busy=0 done=0", q, busy, done);
        end
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_shift();
        logic [7:0] exp_q [3] = '{8'hA5, 8'hD2, 8'h69};
        do_load(8'hA5);
        mode = 3'b001; s_in_msb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) tick();
            if (i == 2) begin s_in_msb = 1'b0; tick(); end
            n_tests++;
            if (q !== exp_q[i]) begin
                n_fail++;
                $display("FAIL load_shift[%0d]: q=%h, want %h", i, q, exp_q[i]);
            end
        end
        mode = 3'b000;
    endtask

    task automatic test_modes();
        logic [7:0] init [5] = '{8'h81, 8'h80, 8'h0F, 8'hFF, 8'h5A};
        logic [2:0] md   [5] = '{3'b100, 3'b110, 3'b010, 3'b111, 3'b000};
        logic [7:0] expv [5] = '{8'h03, 8'hC0, 8'h1F, 8'h00, 8'h5A};
        s_in_lsb = 1'b1; s_in_msb = 1'b0;
        for (int i = 0; i < 5; i++) begin
            do_load(init[i]);
            mode = md[i];
            tick();
            if (i == 4) tick();
            n_tests++;
            if (q !== expv[i]) begin
                n_fail++;
                $display("FAIL mode_%0d: q=%h, want %h", md[i], q, expv[i]);
            end
        end
        mode = 3'b000; s_in_lsb = 1'b0;
    endtask

    task automatic test_burst(input bit stall);
        logic [7:0] exp_q  [4] = '{8'hB4, 8'h5A, 8'h2D, 8'h16};
        logic       exp_lb [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        int busy_cnt = 0;
        mode = 3'b000; p_in = 8'hB4; len = 4'd3; dir = 1'b0; s_in_msb = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            start = 1'b0;
            if (busy) busy_cnt++;
            n_tests++;
            if (q !== exp_q[i] || s_out_lsb !== exp_lb[i] || done !== (i == 3)) begin
                n_fail++;
                $display("FAIL burst%s[%0d]: q=%h lsb=%b done=%b, want q=%h lsb=%b done=%b",
                         stall ? "_stall" : "", i, q, s_out_lsb, done, exp_q[i], exp_lb[i], i == 3);
            end
            if (stall && i == 1) begin
                en = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    tick();
                    if (busy) busy_cnt++;
                end
                en = 1'b1;
            end
        end
        n_tests++;
        if (busy_cnt !== (stall ? 5 : 3)) begin
            n_fail++;
            $display("FAIL burst_busy_len: got %0d cycles, want %0d", busy_cnt, stall ? 5 : 3);
        end
        tick();
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0 || q !== 8'h16) begin
            n_fail++;
            $display("FAIL burst_idle: q=%h busy=%b done=%b, want 16/0/0", q, busy, done);
        end
    endtask

    task automatic test_start_while_busy();
        p_in = 8'hB4; len = 4'd3; dir = 1'b0; s_in_msb = 1'b0; start = 1'b1;
        tick();
        p_in = 8'hFF; len = 4'd0;
        tick();
        tick();
        start = 1'b0;
        tick();
        n_tests++;
        if (q !== 8'h16 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL start_while_busy: q=%h done=%b, want q=16 done=1", q, done);
        end
        tick();
    endtask

    task automatic test_clamp();
        int busy_cnt = 0;
        bit seen_done = 1'b0;
        p_in = 8'hC3; len = 4'd12; dir = 1'b1; s_in_lsb = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 12 && !seen_done; i++) begin
            if (busy) busy_cnt++;
            tick();
            seen_done = done;
        end
        n_tests++;
        if (!seen_done || busy_cnt != 8 || q !== 8'h00) begin
            n_fail++;
            $display("FAIL clamp: done_seen=%b busy=%0d q=%h, want 1/8/00", seen_done, busy_cnt, q);
        end
        tick();
    endtask

    task automatic test_len_zero();
        p_in = 8'h3C; len = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        n_tests++;
        if (q !== 8'h3C || busy !== 1'b0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL len_zero: q=%h busy=%b done=%b, want 3C/0/1", q, busy, done);
        end
        tick();
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL len_zero_after: busy=%b done=%b, want 0/0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        p_in = 8'h81; len = 4'd1; dir = 1'b0; s_in_msb = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        p_in = 8'h11; len = 4'd2; start = 1'b1;
        n_tests++;
        if (done !== 1'b1 || q !== 8'h40) begin
            n_fail++;
            $display("FAIL b2b_first: q=%h done=%b, want 40/1", q, done);
        end
        tick();
        start = 1'b0;
        n_tests++;
        if (busy !== 1'b1 || done !== 1'b0 || q !== 8'h11) begin
            n_fail++;
            $display("FAIL b2b_second: q=%h busy=%b done=%b, want 11/1/0", q, busy, done);
        end
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_abort();
        bit saw_done = 1'b0;
        p_in = 8'hB4; len = 4'd3; dir = 1'b0; s_in_msb = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        tick();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            saw_done |= done;
        end
        n_tests++;
        if (saw_done || q !== 8'h00 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort: done_seen=%b q=%h busy=%b, want 0/00/0", saw_done, q, busy);
        end
        test_burst(1'b0);
    endtask

    task automatic test_random();
        int errs = 0;
        apply_reset();
        m_q = 0; m_left = 0; m_fin = 1'b0; m_dir = 1'b0;
        for (int i = 0; i < 500; i++) begin
            en       = ($urandom_range(0, 7) != 0);
            mode     = 3'($urandom_range(0, 7));
            p_in     = 8'($urandom_range(0, 255));
            start    = ($urandom_range(0, 5) == 0);
            len      = 4'($urandom_range(0, 15));
            dir      = 1'($urandom_range(0, 1));
            s_in_msb = 1'($urandom_range(0, 1));
            s_in_lsb = 1'($urandom_range(0, 1));
            model_step(en, start, int'(mode), int'(p_in), int'(len), dir, s_in_msb, s_in_lsb);
            tick();
            n_tests++;
            if (q !== 8'(m_q) || busy !== (m_left > 0) || done !== m_fin ||
                s_out_lsb !== 1'(m_q % 2) || s_out_msb !== (m_q >= 128)) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random[%0d]: q=%h busy=%b done=%b, want q=%h busy=%b done=%b",
                             i, q, busy, done, 8'(m_q), m_left > 0, m_fin);
            end
        end
        start = 1'b0; en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_load_shift();
        test_modes();
        test_burst(1'b0);
        test_burst(1'b1);
        test_start_while_busy();
        test_clamp();
        test_len_zero();
        test_back_to_back();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register that generalises the team's 8-bit load/shift-right register. It adds configurable width, an asynchronous reset, a clock enable, and eight register modes: hold, both shift directions, rotates, arithmetic shift, load and clear. A built-in burst serialiser loads a word and then shifts it a programmed number of places with a busy/done handshake. It sits between parallel datapaths and bit-serial links: SPI-style serialisers, LFSR seeding, and bit-stream capture.

## Interface
- WIDTH, 8, register width in bits; legal range ≥ 2.
- CNT_W, $clog2(WIDTH+1), width of the burst length and counter; derived, never overridden.
- clk  in  1  rising-edge clock, the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  clock enable; 0 freezes all state except reset.
- mode  in  3  register operation when no burst is running; encoding under Operation.
- s_in_msb  in  1  serial input entering bit WIDTH-1 on right shifts.
- s_in_lsb  in  1  serial input entering bit 0 on left shifts.
- p_in  in  WIDTH  parallel load data.
- start  in  1  burst request, level-sampled.
- len  in  CNT_W  number of burst shifts; values above WIDTH clamp to WIDTH.
- dir  in  1  burst direction: 0 = right, 1 = left.
- q  out  WIDTH  register contents.
- s_out_lsb  out  1  equals q[0].
- s_out_msb  out  1  equals q[WIDTH-1].
- busy  out  1  burst shifting in progress.
- done  out  1  one-cycle burst completion pulse.

## Operation
- Reset while rst_n = 0: q = 0, state = IDLE, busy = 0, done = 0. Reset takes effect immediately, including mid-burst; an aborted burst never pulses done.
- Mode encoding, applied at each enabled edge when the state is not RUN and start is not accepted:
  - 000 hold.
  - 001 shift right: q ← {s_in_msb, q[W-1:1]}. This is the predecessor's shift behaviour.
  - 010 shift left: q ← {q[W-2:0], s_in_lsb}.
  - 011 rotate right.
  - 100 rotate left.
  - 101 load p_in.
  - 110 arithmetic shift right; the MSB is replicated.
  - 111 clear to 0.
- Burst controller states are IDLE, RUN and FIN.
- start is accepted on an enabled edge when the state is IDLE or FIN. Acceptance has priority over mode and does three things:
  - q ← p_in.
  - cnt ← min(len, WIDTH).
  - dir is latched.
- After acceptance the next state is RUN if the clamped length is greater than 0, otherwise FIN.
- In RUN, each enabled edge performs one shift in the latched direction and decrements cnt:
  - right shifts fill bit WIDTH-1 from s_in_msb;
  - left shifts fill bit 0 from s_in_lsb;
  - when cnt = 1, the next state is FIN.
- In RUN, both mode and start are ignored.
- FIN lasts exactly one enabled cycle and then moves to IDLE, unless start is accepted in that cycle.
- busy = (state == RUN); done = (state == FIN). Both are decoded from registered state, with no combinational path from the inputs.

## Timing
- Mode operations have 1-cycle latency: q updates at the edge that samples mode.
- A burst with clamped length N, started at edge T with en held high, behaves as follows:
  - q = p_in after T.
  - busy is high from T through T+N.
  - Shifts occur at edges T+1 … T+N.
  - done is high for the single cycle after edge T+N, and busy falls at that same edge.
- A burst with N = 0 loads p_in and pulses done after T; busy never rises.
- While en = 0, all state holds. A stall during RUN lengthens busy by the number of stalled cycles. A stall during FIN stretches done.
- Back-to-back bursts: a start accepted during FIN makes done and the new busy period contiguous, with no idle cycle.
- s_out_lsb and s_out_msb follow q with no added latency.

## Structure
- Package shift_reg_pkg holds:
  - the mode localparams (MODE_HOLD … MODE_CLR);
  - the burst state encoding (ST_IDLE, ST_RUN, ST_FIN);
  - the direction constants DIR_R and DIR_L.
- Sub-module shift_burst_ctrl contains the state register, the down-counter and the length clamp. It outputs busy, done, a shift strobe, the latched direction and the load strobe.
- The top level holds the datapath mux and the q register.

## Test plan
- Reset: assert rst_n = 0 mid-run → q = 0x00, busy = 0, done = 0 immediately, without waiting for a clock edge.
- Load and shift right, all with mode held:
  - load with p_in = 0xA5 → q = 0xA5;
  - shift right with s_in_msb = 1 → q = 0xD2;
  - shift right with s_in_msb = 0 → q = 0x69.
- Remaining modes, checked independently:
  - rotate left from 0x81 → 0x03;
  - arithmetic shift right from 0x80 → 0xC0;
  - shift left with s_in_lsb = 1 from 0x0F → 0x1F;
  - clear from 0xFF → 0x00;
  - hold keeps the value.
- Burst: start with p_in = 0xB4, len = 3, dir = 0, s_in_msb = 0 →
  - q sequence 0xB4, 0x5A, 0x2D, 0x16;
  - s_out_lsb sequence 0, 0, 1, 0;
  - busy high for exactly 3 cycles, then done for 1 cycle.
- Burst edge cases:
  - en = 0 for 2 cycles mid-burst → busy is 5 cycles long and the final q is unchanged;
  - start while busy → ignored;
  - len = 12 with dir = 1 and s_in_lsb = 0 → clamps to 8 and q = 0x00;
  - len = 0 → load plus a done pulse, busy never rises.
- Abort and restart: rst_n low for one cycle during RUN → done never pulses and q = 0. A new start after reset runs normally.
